// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback sources.
// Optional read-port bypass of the in-flight write is enabled by defining WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic [CNT_W-1:0]            conflict_cnt,
  input  logic [ADDR_W-1:0]           rd_addr1,
  input  logic [ADDR_W-1:0]           rd_addr2,
  input  logic [DATA_W-1:0]           rd_data1_in,
  input  logic [DATA_W-1:0]           rd_data2_in,
  output logic [DATA_W-1:0]           rd_data1_out,
  output logic [DATA_W-1:0]           rd_data2_out
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr_q,   rr_ptr_d;
  logic              rf_we_q,    rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [DATA_W-1:0]  gnt_data;
  int unsigned        idx;
  logic               multi_req;

  // Scan from rr_ptr with wraparound; first valid source wins.
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_addr = '0;
    gnt_data = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt[idx] = 1'b1;
        gnt_any  = 1'b1;
        gnt_idx  = PTR_W'(idx);
        gnt_addr = req_addr[idx*ADDR_W +: ADDR_W];
        gnt_data = req_data[idx*DATA_W +: DATA_W];
      end
    end
  end

  assign multi_req = ($countones(req_valid) > 1);

  // Next-state for pointer, output stage and contention counter.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    cnt_d      = cnt_q;
    if (gnt_any) begin
      rr_ptr_d   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : PTR_W'(gnt_idx + 1'b1);
      rf_we_d    = (gnt_addr != '0);
      rf_waddr_d = gnt_addr;
      rf_wdata_d = gnt_data;
    end
    if (multi_req && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      cnt_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      cnt_q      <= cnt_d;
    end
  end

  // Grant is same-cycle; forced low while reset is asserted.
  assign req_ready    = rst_n ? gnt : '0;
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign conflict_cnt = cnt_q;

`ifdef WB_BYPASS_EN
  // Forward the write being committed this cycle to readers of the same register.
  assign rd_data1_out = (rf_we_q && (rf_waddr_q == rd_addr1) && (rd_addr1 != '0)) ? rf_wdata_q : rd_data1_in;
  assign rd_data2_out = (rf_we_q && (rf_waddr_q == rd_addr2) && (rd_addr2 != '0)) ? rf_wdata_q : rd_data2_in;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr1, rd_addr2};
  assign rd_data1_out   = rd_data1_in;
  assign rd_data2_out   = rd_data2_in;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NUM_REQ=3, ADDR_W=5, DATA_W=32, CNT_W=16).
module tb_regfile_wb_arbiter;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 16;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic [CNT_W-1:0]          conflict_cnt;
  logic [ADDR_W-1:0]         rd_addr1, rd_addr2;
  logic [DATA_W-1:0]         rd_data1_in, rd_data2_in;
  logic [DATA_W-1:0]         rd_data1_out, rd_data2_out;

  int checks = 0;
  int failures = 0;

  regfile_wb_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .conflict_cnt(conflict_cnt),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1_in(rd_data1_in), .rd_data2_in(rd_data2_in),
    .rd_data1_out(rd_data1_out), .rd_data2_out(rd_data2_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_valid[i] = v;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] exp_byp;

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    rd_addr1 = '0; rd_addr2 = '0; rd_data1_in = '0; rd_data2_in = '0;

    // Reset held with every source requesting
    set_src(0, 1'b1, 5'd1, 32'hA0);
    set_src(1, 1'b1, 5'd2, 32'hA1);
    set_src(2, 1'b1, 5'd3, 32'hA2);
    #20;
    check_eq("rst_rf_we", 64'(rf_we), 64'd0);
    check_eq("rst_ready", 64'(req_ready), 64'd0);
    check_eq("rst_cnt", 64'(conflict_cnt), 64'd0);
    check_eq("rst_waddr", 64'(rf_waddr), 64'd0);
    check_eq("rst_wdata", 64'(rf_wdata), 64'd0);

    // Release mid-cycle: source 0 first, then strict rotation
    #2 rst_n = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("rr_ready_%0d", i), 64'(req_ready), 64'(3'b001 << (i % 3)));
      tick();
      check_eq($sformatf("rr_we_%0d", i), 64'(rf_we), 64'd1);
      check_eq($sformatf("rr_waddr_%0d", i), 64'(rf_waddr), 64'((i % 3) + 1));
      check_eq($sformatf("rr_wdata_%0d", i), 64'(rf_wdata), 64'(32'hA0 + (i % 3)));
    end
    check_eq("rr_cnt", 64'(conflict_cnt), 64'd6);
    req_valid = '0;

    // Single source 1 (pointer at 0)
    set_src(1, 1'b1, 5'd8, 32'hDEADBEEF);
    #1 check_eq("single_ready", 64'(req_ready), 64'(3'b010));
    tick();
    check_eq("single_we", 64'(rf_we), 64'd1);
    check_eq("single_waddr", 64'(rf_waddr), 64'd8);
    check_eq("single_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    req_valid = '0;
    tick();
    check_eq("idle_we", 64'(rf_we), 64'd0);
    check_eq("idle_waddr_hold", 64'(rf_waddr), 64'd8);
    check_eq("idle_wdata_hold", 64'(rf_wdata), 64'hDEADBEEF);
    check_eq("idle_cnt", 64'(conflict_cnt), 64'd6);

    // $zero write from source 2 (pointer at 2)
    set_src(2, 1'b1, 5'd0, 32'h55);
    #1 check_eq("zero_ready", 64'(req_ready), 64'(3'b100));
    tick();
    check_eq("zero_we", 64'(rf_we), 64'd0);
    // Pointer wrapped to 0: with 0 and 2 valid, 0 must win
    set_src(0, 1'b1, 5'd1, 32'hA0);
    set_src(2, 1'b1, 5'd3, 32'hA2);
    #1 check_eq("wrap_ready", 64'(req_ready), 64'(3'b001));
    tick();
    check_eq("wrap_cnt", 64'(conflict_cnt), 64'd7);
    check_eq("wrap_waddr", 64'(rf_waddr), 64'd1);
    req_valid = '0;

    // Same destination from 0 and 1 (pointer at 1): 1 then 0, last wins
    set_src(0, 1'b1, 5'd9, 32'h111);
    set_src(1, 1'b1, 5'd9, 32'h222);
    #1 check_eq("same_ready1", 64'(req_ready), 64'(3'b010));
    tick();
    check_eq("same_wdata1", 64'(rf_wdata), 64'h222);
    req_valid[1] = 1'b0;
    #1 check_eq("same_ready0", 64'(req_ready), 64'(3'b001));
    tick();
    check_eq("same_wdata0", 64'(rf_wdata), 64'h111);
    check_eq("same_waddr", 64'(rf_waddr), 64'd9);
    check_eq("same_cnt", 64'(conflict_cnt), 64'd8);
    req_valid = '0;

    // Bypass window: in-flight write to r5
    set_src(0, 1'b1, 5'd5, 32'h1234);
    tick();
    req_valid = '0;
    check_eq("byp_we", 64'(rf_we), 64'd1);
    rd_addr1 = 5'd5; rd_data1_in = 32'h0;
    rd_addr2 = 5'd5; rd_data2_in = 32'h77;
    #1;
`ifdef WB_BYPASS_EN
    exp_byp = 32'h1234;
`else
    exp_byp = 32'h0;
`endif
    check_eq("byp_rd1_hit", 64'(rd_data1_out), 64'(exp_byp));
`ifdef WB_BYPASS_EN
    exp_byp = 32'h1234;
`else
    exp_byp = 32'h77;
`endif
    check_eq("byp_rd2_hit", 64'(rd_data2_out), 64'(exp_byp));
    rd_addr1 = 5'd0; rd_data1_in = 32'hCAFE;
    #1 check_eq("byp_rd1_zero", 64'(rd_data1_out), 64'hCAFE);
    rd_addr2 = 5'd6; rd_data2_in = 32'h99;
    #1 check_eq("byp_rd2_miss", 64'(rd_data2_out), 64'h99);

    // Async reset between edges discards the pending write
    set_src(1, 1'b1, 5'd12, 32'hBEEF);
    tick();
    check_eq("mid_we_before", 64'(rf_we), 64'd1);
    set_src(1, 1'b1, 5'd13, 32'hF00D);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_we", 64'(rf_we), 64'd0);
    check_eq("mid_rst_waddr", 64'(rf_waddr), 64'd0);
    check_eq("mid_rst_wdata", 64'(rf_wdata), 64'd0);
    check_eq("mid_rst_ready", 64'(req_ready), 64'd0);
    check_eq("mid_rst_cnt", 64'(conflict_cnt), 64'd0);
    tick();
    req_valid = '0;
    #2 rst_n = 1'b1;
    tick();
    check_eq("post_rst_we", 64'(rf_we), 64'd0);
    check_eq("post_rst_wdata", 64'(rf_wdata), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
